// File: rtl/chip_74138n.sv
// Self-running tester for a 74138 3-to-8 decoder: sweeps all 64 address/enable
// vectors, samples the synchronised active-low outputs and records pass/fail.
//
// state  | meaning
// HALTED | idle, results held, waiting for Run
// SET    | one cycle, clears vector counter and results
// TEST   | vector sweep, compare at end of each settle window
// DONE_S | Done asserted until DISP_RSLT
`timescale 1ns/1ps

module chip_74138n #(
  parameter int unsigned SETTLE = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       DISP_RSLT,
  output logic       Pin1,
  output logic       Pin2,
  output logic       Pin3,
  output logic       Pin4,
  output logic       Pin5,
  output logic       Pin6,
  input  logic       Pin15,
  input  logic       Pin14,
  input  logic       Pin13,
  input  logic       Pin12,
  input  logic       Pin11,
  input  logic       Pin10,
  input  logic       Pin9,
  input  logic       Pin7,
  output logic       Done,
  output logic       RSLT,
  output logic [5:0] FailVec,
  output logic [6:0] FailCount
);

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    SET    = 2'd1,
    TEST   = 2'd2,
    DONE_S = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [5:0] V_LAST   = 6'd63;

  state_t      state_q, state_d;
  logic [5:0]  v_q, v_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [5:0]  pins_q, pins_d;
  logic [7:0]  sync1_q, sync2_q;
  logic        rslt_q, rslt_d;
  logic [5:0]  fail_vec_q, fail_vec_d;
  logic [6:0]  fail_count_q, fail_count_d;

  logic [7:0]  y_raw;
  logic [7:0]  y_exp;
  logic        chip_en;
  logic        sample;

  assign y_raw = {Pin7, Pin9, Pin10, Pin11, Pin12, Pin13, Pin14, Pin15};

  // G1=V[5], G2A_n=V[4], G2B_n=V[3], select={C,B,A}=V[2:0]
  always_comb begin
    y_exp   = 8'hFF;
    chip_en = v_q[5] & ~v_q[4] & ~v_q[3];
    if (chip_en) begin
      y_exp[v_q[2:0]] = 1'b0;
    end
  end

  assign sample = (state_q == TEST) && (dwell_q == SETTLE_C);

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    dwell_d      = dwell_q;
    rslt_d       = rslt_q;
    fail_vec_d   = fail_vec_q;
    fail_count_d = fail_count_q;
    case (state_q)
      HALTED: begin
        if (Run) begin
          state_d = SET;
        end
      end
      SET: begin
        v_d          = 6'd0;
        dwell_d      = 4'd0;
        rslt_d       = 1'b1;
        fail_vec_d   = 6'd0;
        fail_count_d = 7'd0;
        state_d      = TEST;
      end
      TEST: begin
        if (sample) begin
          if (sync2_q != y_exp) begin
            fail_count_d = fail_count_q + 7'd1;
            if (fail_count_q == 7'd0) begin
              rslt_d     = 1'b0;
              fail_vec_d = v_q;
            end
          end
          if (v_q == V_LAST) begin
            state_d = DONE_S;
          end else begin
            v_d     = v_q + 6'd1;
            dwell_d = 4'd0;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      DONE_S: begin
        if (DISP_RSLT) begin
          state_d = HALTED;
        end
      end
      default: state_d = HALTED;
    endcase
    // Pins follow the next vector so the chip sees it from the first Test cycle.
    pins_d = (state_d == TEST) ? v_d : 6'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= HALTED;
      v_q          <= 6'd0;
      dwell_q      <= 4'd0;
      pins_q       <= 6'd0;
      sync1_q      <= 8'd0;
      sync2_q      <= 8'd0;
      rslt_q       <= 1'b0;
      fail_vec_q   <= 6'd0;
      fail_count_q <= 7'd0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      dwell_q      <= dwell_d;
      pins_q       <= pins_d;
      sync1_q      <= y_raw;
      sync2_q      <= sync1_q;
      rslt_q       <= rslt_d;
      fail_vec_q   <= fail_vec_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign Pin1 = pins_q[0];
  assign Pin2 = pins_q[1];
  assign Pin3 = pins_q[2];
  assign Pin4 = pins_q[4];
  assign Pin5 = pins_q[3];
  assign Pin6 = pins_q[5];

  assign Done = (state_q == DONE_S) || (sample && (v_q == V_LAST));

  assign RSLT      = rslt_q;
  assign FailVec   = fail_vec_q;
  assign FailCount = fail_count_q;

endmodule

// File: tb/tb_chip_74138n.sv
// Directed bench for chip_74138n: one tester on an ideal/faulty 74138 model,
// a second (SETTLE=2) on a model with negedge-clocked output delay stages.
`timescale 1ns/1ps

module tb_chip_74138n;

  logic clk = 1'b0;
  logic reset;
  logic run1, disp1, run2, disp2;
  int   fault1;
  int   delay_sel;
  int   total = 0;
  int   bad = 0;

  logic p1_1, p1_2, p1_3, p1_4, p1_5, p1_6;
  logic p2_1, p2_2, p2_3, p2_4, p2_5, p2_6;
  logic done1, rslt1, done2, rslt2;
  logic [5:0] fv1, fv2;
  logic [6:0] fc1, fc2;
  logic [5:0] v1, v2;
  logic [7:0] y1, y2, y2_comb;
  logic [7:0] d1 = 8'hFF, d2 = 8'hFF, d3 = 8'hFF;

  always #5 clk = ~clk;

  // vector as {G1, G2A_n, G2B_n, C, B, A}
  assign v1 = {p1_6, p1_4, p1_5, p1_3, p1_2, p1_1};
  assign v2 = {p2_6, p2_4, p2_5, p2_3, p2_2, p2_1};

  // fault: 0 ideal, 1 Y3 stuck high, 2 G1 ignored
  function automatic logic [7:0] model(input logic [5:0] v, input int fault);
    logic [7:0] y;
    logic en;
    en = ((fault == 2) ? 1'b1 : v[5]) & ~v[4] & ~v[3];
    y = 8'hFF;
    if (en) y[v[2:0]] = 1'b0;
    if (fault == 1) y[3] = 1'b1;
    return y;
  endfunction

  assign y1      = model(v1, fault1);
  assign y2_comb = model(v2, 0);

  always @(negedge clk) begin
    d1 <= y2_comb;
    d2 <= d1;
    d3 <= d2;
  end
  assign y2 = (delay_sel == 1) ? d1 : d3;

  chip_74138n #(.SETTLE(3)) u_dut (
    .Clk(clk), .Reset(reset), .Run(run1), .DISP_RSLT(disp1),
    .Pin1(p1_1), .Pin2(p1_2), .Pin3(p1_3), .Pin4(p1_4), .Pin5(p1_5), .Pin6(p1_6),
    .Pin15(y1[0]), .Pin14(y1[1]), .Pin13(y1[2]), .Pin12(y1[3]),
    .Pin11(y1[4]), .Pin10(y1[5]), .Pin9(y1[6]), .Pin7(y1[7]),
    .Done(done1), .RSLT(rslt1), .FailVec(fv1), .FailCount(fc1)
  );

  chip_74138n #(.SETTLE(2)) u_dut2 (
    .Clk(clk), .Reset(reset), .Run(run2), .DISP_RSLT(disp2),
    .Pin1(p2_1), .Pin2(p2_2), .Pin3(p2_3), .Pin4(p2_4), .Pin5(p2_5), .Pin6(p2_6),
    .Pin15(y2[0]), .Pin14(y2[1]), .Pin13(y2[2]), .Pin12(y2[3]),
    .Pin11(y2[4]), .Pin10(y2[5]), .Pin9(y2[6]), .Pin7(y2[7]),
    .Done(done2), .RSLT(rslt2), .FailVec(fv2), .FailCount(fc2)
  );

  // Pulses Run and returns the number of edges until Done rises (-1 on timeout).
  task automatic run_and_wait(input int sel, output int n);
    if (sel == 1) run1 = 1'b1; else run2 = 1'b1;
    @(posedge clk); #1;
    run1 = 1'b0; run2 = 1'b0;
    n = 0;
    while (!((sel == 1) ? done1 : done2) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) n = -1;
  endtask

  task automatic ack(input int sel);
    if (sel == 1) disp1 = 1'b1; else disp2 = 1'b1;
    @(posedge clk); #1;
    disp1 = 1'b0; disp2 = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done1); end
    total++; if (rslt1 !== 1'b0) begin bad++; $display("FAIL reset_rslt got=%0b want=0", rslt1); end
    total++; if (fv1 !== 6'd0) begin bad++; $display("FAIL reset_failvec got=%0h want=0", fv1); end
    total++; if (fc1 !== 7'd0) begin bad++; $display("FAIL reset_failcount got=%0d want=0", fc1); end
    total++; if (v1 !== 6'd0) begin bad++; $display("FAIL reset_pins got=%0h want=0", v1); end
    total++; if ({done2, rslt2, fv2, fc2, v2} !== 21'd0) begin bad++; $display("FAIL reset_dut2 got=%0h want=0", {done2, rslt2, fv2, fc2, v2}); end
  endtask

  task automatic test_ideal();
    int n;
    fault1 = 0;
    run_and_wait(1, n);
    total++; if (n !== 256) begin bad++; $display("FAIL ideal_cycles got=%0d want=256", n); end
    @(posedge clk); #1;
    total++; if (done1 !== 1'b1) begin bad++; $display("FAIL ideal_done got=%0b want=1", done1); end
    total++; if (rslt1 !== 1'b1) begin bad++; $display("FAIL ideal_rslt got=%0b want=1", rslt1); end
    total++; if (fc1 !== 7'd0) begin bad++; $display("FAIL ideal_failcount got=%0d want=0", fc1); end
    total++; if (fv1 !== 6'd0) begin bad++; $display("FAIL ideal_failvec got=%0h want=0", fv1); end
    total++; if (v1 !== 6'd0) begin bad++; $display("FAIL ideal_pins_released got=%0h want=0", v1); end
    ack(1);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL ideal_ack_done got=%0b want=0", done1); end
  endtask

  task automatic test_pin_map();
    int n;
    fault1 = 0;
    run1 = 1'b1;
    @(posedge clk); #1;
    run1 = 1'b0;
    @(posedge clk); #1;
    total++; if (v1 !== 6'd0) begin bad++; $display("FAIL pins_v0 got=%0h want=0", v1); end
    repeat (4) @(posedge clk); #1;
    total++; if ({p1_6, p1_5, p1_4, p1_3, p1_2, p1_1} !== 6'b000001) begin bad++; $display("FAIL pins_v1 got=%0b want=000001", {p1_6, p1_5, p1_4, p1_3, p1_2, p1_1}); end
    repeat (172) @(posedge clk); #1;
    // V=44: G1=1 G2A_n=0 G2B_n=1 C=1 B=0 A=0
    total++; if ({p1_6, p1_5, p1_4, p1_3, p1_2, p1_1} !== 6'b110100) begin bad++; $display("FAIL pins_v44 got=%0b want=110100", {p1_6, p1_5, p1_4, p1_3, p1_2, p1_1}); end
    n = 0;
    while (!done1 && n < 2000) begin @(posedge clk); #1; n++; end
    total++; if (n !== 79) begin bad++; $display("FAIL pins_remaining_cycles got=%0d want=79", n); end
    @(posedge clk); #1;
    ack(1);
  endtask

  task automatic test_y3_stuck();
    int n;
    fault1 = 1;
    run_and_wait(1, n);
    @(posedge clk); #1;
    total++; if (rslt1 !== 1'b0) begin bad++; $display("FAIL y3_rslt got=%0b want=0", rslt1); end
    total++; if (fv1 !== 6'h23) begin bad++; $display("FAIL y3_failvec got=%0h want=23", fv1); end
    total++; if (fc1 !== 7'd1) begin bad++; $display("FAIL y3_failcount got=%0d want=1", fc1); end
    ack(1);
    fault1 = 0;
  endtask

  task automatic test_g1_ignored();
    int n;
    fault1 = 2;
    run_and_wait(1, n);
    @(posedge clk); #1;
    total++; if (rslt1 !== 1'b0) begin bad++; $display("FAIL g1_rslt got=%0b want=0", rslt1); end
    total++; if (fv1 !== 6'h00) begin bad++; $display("FAIL g1_failvec got=%0h want=0", fv1); end
    total++; if (fc1 !== 7'd8) begin bad++; $display("FAIL g1_failcount got=%0d want=8", fc1); end
    ack(1);
    fault1 = 0;
  endtask

  task automatic test_done_hold();
    int n;
    fault1 = 1;
    run_and_wait(1, n);
    @(posedge clk); #1;
    fault1 = 0;
    run1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      total++;
      if ({done1, rslt1, fv1, fc1} !== {1'b1, 1'b0, 6'h23, 7'd1}) begin
        bad++; $display("FAIL hold_cycle%0d got=%0h want=%0h", i, {done1, rslt1, fv1, fc1}, {1'b1, 1'b0, 6'h23, 7'd1});
      end
    end
    disp1 = 1'b1;
    @(posedge clk); #1;
    run1 = 1'b0; disp1 = 1'b0;
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL hold_ack_done got=%0b want=0", done1); end
    total++; if ({rslt1, fv1, fc1} !== {1'b0, 6'h23, 7'd1}) begin bad++; $display("FAIL hold_retained got=%0h want=%0h", {rslt1, fv1, fc1}, {1'b0, 6'h23, 7'd1}); end
    repeat (6) @(posedge clk); #1;
    total++; if ({done1, v1} !== 7'd0) begin bad++; $display("FAIL hold_stays_halted got=%0h want=0", {done1, v1}); end
  endtask

  task automatic test_back_to_back();
    int n;
    fault1 = 0;
    run_and_wait(1, n);
    @(posedge clk); #1;
    total++; if ({rslt1, fv1, fc1} !== {1'b1, 6'h00, 7'd0}) begin bad++; $display("FAIL rerun_cleared got=%0h want=%0h", {rslt1, fv1, fc1}, {1'b1, 6'h00, 7'd0}); end
    ack(1);
  endtask

  task automatic test_reset_mid();
    int n;
    fault1 = 2;
    run1 = 1'b1;
    @(posedge clk); #1;
    run1 = 1'b0;
    n = 0;
    while (v1 !== 6'd20 && n < 2000) begin @(posedge clk); #1; n++; end
    total++; if (n >= 2000) begin bad++; $display("FAIL midreset_reach_v20 got=timeout want=v20"); end
    total++; if (fc1 !== 7'd8) begin bad++; $display("FAIL midreset_pre_failcount got=%0d want=8", fc1); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({done1, rslt1, fv1, fc1, v1} !== 21'd0) begin bad++; $display("FAIL midreset_state got=%0h want=0", {done1, rslt1, fv1, fc1, v1}); end
    repeat (6) @(posedge clk); #1;
    total++; if ({done1, v1} !== 7'd0) begin bad++; $display("FAIL midreset_halted got=%0h want=0", {done1, v1}); end
    fault1 = 0;
    run_and_wait(1, n);
    total++; if (n !== 256) begin bad++; $display("FAIL midreset_rerun_cycles got=%0d want=256", n); end
    @(posedge clk); #1;
    total++; if ({rslt1, fc1} !== {1'b1, 7'd0}) begin bad++; $display("FAIL midreset_rerun_result got=%0h want=%0h", {rslt1, fc1}, {1'b1, 7'd0}); end
    ack(1);
  endtask

  task automatic test_delay();
    int n;
    delay_sel = 1;
    run_and_wait(2, n);
    total++; if (n !== 192) begin bad++; $display("FAIL delay1_cycles got=%0d want=192", n); end
    @(posedge clk); #1;
    total++; if ({rslt2, fc2} !== {1'b1, 7'd0}) begin bad++; $display("FAIL delay1_result got=%0h want=%0h", {rslt2, fc2}, {1'b1, 7'd0}); end
    ack(2);
    delay_sel = 3;
    repeat (4) @(posedge clk); #1;
    run_and_wait(2, n);
    @(posedge clk); #1;
    total++; if (rslt2 !== 1'b0) begin bad++; $display("FAIL delay3_rslt got=%0b want=0", rslt2); end
    total++; if (fv2 !== 6'd32) begin bad++; $display("FAIL delay3_failvec got=%0d want=32", fv2); end
    total++; if (fc2 !== 7'd9) begin bad++; $display("FAIL delay3_failcount got=%0d want=9", fc2); end
    ack(2);
  endtask

  initial begin
    reset = 1'b1;
    run1 = 1'b0; disp1 = 1'b0; run2 = 1'b0; disp2 = 1'b0;
    fault1 = 0;
    delay_sel = 1;
    repeat (3) @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_ideal();
    test_pin_map();
    test_y3_stuck();
    test_g1_ignored();
    test_done_hold();
    test_back_to_back();
    test_reset_mid();
    test_delay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
